// File: rtl/dct_coef_reorder.sv
// -----------------------------------------------------------------------------
// dct_coef_reorder
//
// This block receives 8x8 DCT/IDCT coefficients that arrive in any index order.
// It stores them in a double-buffered store with two banks of 64 words each.
// Each complete block is then streamed out in JPEG zigzag order or in raster
// order.
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous, active-high reset
//   dct_out_en     coefficient write strobe
//   dct_out_idx    raster index of the coefficient (row*8+col)
//   dct_output     coefficient value, passed through unmodified
//   in_ready       high while the current write bank is not full
//   out_valid      output beat valid
//   out_ready      downstream accepts the beat
//   out_data       coefficient of the current beat
//   out_idx        raster index of out_data
//   out_last       high on the 64th beat of a block
//   ovf_err        sticky flag, set by a write seen while in_ready was low
//   rd_state_dbg   current read-FSM state (IDLE=0, PRIME=1, STREAM=2)
//
// Output handshake: a beat transfers on a rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// out_data, out_idx and out_last hold their values. out_valid never drops
// until its beat has transferred.
// -----------------------------------------------------------------------------
module dct_coef_reorder #(
    parameter int D_WIDTH = 13,
    parameter bit ZIGZAG  = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               dct_out_en,
    input  logic [5:0]         dct_out_idx,
    input  logic [D_WIDTH-1:0] dct_output,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_data,
    output logic [5:0]         out_idx,
    output logic               out_last,
    output logic               ovf_err,
    output logic [1:0]         rd_state_dbg
);

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_PRIME  = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_e;

    // Map a scan position to the raster address that is read from the bank.
    function automatic logic [5:0] scan_addr(input logic [5:0] k);
        logic [5:0] a;
        if (!ZIGZAG) begin
            a = k;
        end else begin
            case (k)
                6'd0:  a = 6'd0;  6'd1:  a = 6'd1;  6'd2:  a = 6'd8;  6'd3:  a = 6'd16;
                6'd4:  a = 6'd9;  6'd5:  a = 6'd2;  6'd6:  a = 6'd3;  6'd7:  a = 6'd10;
                6'd8:  a = 6'd17; 6'd9:  a = 6'd24; 6'd10: a = 6'd32; 6'd11: a = 6'd25;
                6'd12: a = 6'd18; 6'd13: a = 6'd11; 6'd14: a = 6'd4;  6'd15: a = 6'd5;
                6'd16: a = 6'd12; 6'd17: a = 6'd19; 6'd18: a = 6'd26; 6'd19: a = 6'd33;
                6'd20: a = 6'd40; 6'd21: a = 6'd48; 6'd22: a = 6'd41; 6'd23: a = 6'd34;
                6'd24: a = 6'd27; 6'd25: a = 6'd20; 6'd26: a = 6'd13; 6'd27: a = 6'd6;
                6'd28: a = 6'd7;  6'd29: a = 6'd14; 6'd30: a = 6'd21; 6'd31: a = 6'd28;
                6'd32: a = 6'd35; 6'd33: a = 6'd42; 6'd34: a = 6'd49; 6'd35: a = 6'd56;
                6'd36: a = 6'd57; 6'd37: a = 6'd50; 6'd38: a = 6'd43; 6'd39: a = 6'd36;
                6'd40: a = 6'd29; 6'd41: a = 6'd22; 6'd42: a = 6'd15; 6'd43: a = 6'd23;
                6'd44: a = 6'd30; 6'd45: a = 6'd37; 6'd46: a = 6'd44; 6'd47: a = 6'd51;
                6'd48: a = 6'd58; 6'd49: a = 6'd59; 6'd50: a = 6'd52; 6'd51: a = 6'd45;
                6'd52: a = 6'd38; 6'd53: a = 6'd31; 6'd54: a = 6'd39; 6'd55: a = 6'd46;
                6'd56: a = 6'd53; 6'd57: a = 6'd60; 6'd58: a = 6'd61; 6'd59: a = 6'd54;
                6'd60: a = 6'd47; 6'd61: a = 6'd55; 6'd62: a = 6'd62; 6'd63: a = 6'd63;
                default: a = k;
            endcase
        end
        return a;
    endfunction

    // Storage: bank b occupies mem_q[{b, idx}]
    logic [D_WIDTH-1:0] mem_q [128];
    logic [1:0][63:0]   mask_q;
    logic [1:0]         full_q;
    logic               wr_bank_q;
    logic               rd_bank_q;
    logic               ovf_q;

    // Read side
    rd_state_e          state_q, state_d;
    logic [5:0]         k_q, k_d;
    logic               out_valid_q, out_valid_d;
    logic [5:0]         out_idx_q, out_idx_d;
    logic               out_last_q, out_last_d;
    logic [D_WIDTH-1:0] out_data_q;
    logic               rd_en;
    logic [5:0]         rd_k;
    logic [5:0]         rd_addr;
    logic               release_bank;

    // Write side decode
    logic               wr_fire;
    logic [63:0]        wr_mask_next;
    logic               wr_complete;

    assign in_ready     = !full_q[wr_bank_q];
    assign wr_fire      = dct_out_en && in_ready;
    assign wr_mask_next = mask_q[wr_bank_q] | (64'd1 << dct_out_idx);
    assign wr_complete  = wr_fire && (&wr_mask_next);

    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem_q[{wr_bank_q, dct_out_idx}] <= dct_output;
        end
    end

    // A bank that is being released is full, so it is never the write bank.
    // A release and a write in the same cycle therefore always touch
    // different banks.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mask_q    <= '0;
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (release_bank) begin
                mask_q[rd_bank_q] <= '0;
                full_q[rd_bank_q] <= 1'b0;
                rd_bank_q         <= ~rd_bank_q;
            end
            if (wr_fire) begin
                mask_q[wr_bank_q] <= wr_mask_next;
                if (wr_complete) begin
                    full_q[wr_bank_q] <= 1'b1;
                    wr_bank_q         <= ~wr_bank_q;
                end
            end
            if (dct_out_en && !in_ready) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Read FSM. Whenever a beat is loaded (PRIME, or an accepted
    // non-final beat), the next scan position is read from the bank.
    // This keeps the beats back-to-back while out_ready stays high.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        out_valid_d  = out_valid_q;
        out_idx_d    = out_idx_q;
        out_last_d   = out_last_q;
        rd_en        = 1'b0;
        rd_k         = 6'd0;
        release_bank = 1'b0;
        rd_addr      = 6'd0;

        case (state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = RD_PRIME;
                end
            end
            RD_PRIME: begin
                rd_en   = 1'b1;
                rd_k    = 6'd0;
                state_d = RD_STREAM;
            end
            RD_STREAM: begin
                if (out_valid_q && out_ready) begin
                    if (k_q == 6'd63) begin
                        release_bank = 1'b1;
                        out_valid_d  = 1'b0;
                        out_last_d   = 1'b0;
                        state_d      = full_q[~rd_bank_q] ? RD_PRIME : RD_IDLE;
                    end else begin
                        rd_en = 1'b1;
                        rd_k  = k_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase

        rd_addr = scan_addr(rd_k);
        if (rd_en) begin
            k_d         = rd_k;
            out_valid_d = 1'b1;
            out_idx_d   = rd_addr;
            out_last_d  = (rd_k == 6'd63);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= RD_IDLE;
            k_q         <= 6'd0;
            out_valid_q <= 1'b0;
            out_idx_q   <= 6'd0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            if (rd_en) begin
                out_data_q <= mem_q[{rd_bank_q, rd_addr}];
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_idx      = out_idx_q;
    assign out_last     = out_last_q;
    assign ovf_err      = ovf_q;
    assign rd_state_dbg = state_q;

endmodule

// File: tb/tb_dct_coef_reorder.sv
// -----------------------------------------------------------------------------
// tb_dct_coef_reorder
//
// Drives one input stream into two instances: one built for zigzag order and
// one for raster order. A reference model builds the expected beat stream.
// It derives the zigzag order by walking the anti-diagonals of the 8x8 block.
// -----------------------------------------------------------------------------
module tb_dct_coef_reorder;
  localparam int DW = 13;
  localparam int EW = 1 + 6 + DW;

  // clock / reset
  logic clock;
  logic reset;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // stimulus
  logic          dct_out_en;
  logic [5:0]    dct_out_idx;
  logic [DW-1:0] dct_output;
  logic          out_ready;

  // zigzag instance outputs
  logic          in_ready_z, out_valid_z, out_last_z, ovf_z;
  logic [DW-1:0] out_data_z;
  logic [5:0]    out_idx_z;
  logic [1:0]    dbg_z;
  // raster instance outputs
  logic          in_ready_r, out_valid_r, out_last_r, ovf_r;
  logic [DW-1:0] out_data_r;
  logic [5:0]    out_idx_r;
  logic [1:0]    dbg_r;

  dct_coef_reorder #(.D_WIDTH(DW), .ZIGZAG(1'b1)) u_zz (
    .clock(clock), .reset(reset), .dct_out_en(dct_out_en), .dct_out_idx(dct_out_idx),
    .dct_output(dct_output), .in_ready(in_ready_z), .out_valid(out_valid_z),
    .out_ready(out_ready), .out_data(out_data_z), .out_idx(out_idx_z),
    .out_last(out_last_z), .ovf_err(ovf_z), .rd_state_dbg(dbg_z)
  );

  dct_coef_reorder #(.D_WIDTH(DW), .ZIGZAG(1'b0)) u_rs (
    .clock(clock), .reset(reset), .dct_out_en(dct_out_en), .dct_out_idx(dct_out_idx),
    .dct_output(dct_output), .in_ready(in_ready_r), .out_valid(out_valid_r),
    .out_ready(out_ready), .out_data(out_data_r), .out_idx(out_idx_r),
    .out_last(out_last_r), .ovf_err(ovf_r), .rd_state_dbg(dbg_r)
  );

  // reference model and scoreboard
  logic [DW-1:0]   ref_mem [64];
  bit              ref_written [64];
  int              ref_cnt;
  int              pending;
  bit              ovf_exp;
  int              zz_order [64];
  logic [2*EW-1:0] exp_q [$];   // {zigzag beat, raster beat}, each {last, idx, data}
  bit              rand_ready;
  int              beats_in_blk;
  bit              hold_v;
  logic [EW:0]     hold_z, hold_r;
  int              checks;
  int              failures;
  int              perm [64];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic build_zz();
    int n;
    int c;
    n = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = 7; r >= 0; r--) begin
          c = s - r;
          if (c >= 0 && c < 8) begin zz_order[n] = r * 8 + c; n++; end
        end
      end else begin
        for (int r = 0; r < 8; r++) begin
          c = s - r;
          if (c >= 0 && c < 8) begin zz_order[n] = r * 8 + c; n++; end
        end
      end
    end
  endtask

  task automatic push_block();
    logic [EW-1:0] ez, er;
    for (int k = 0; k < 64; k++) begin
      ez = {(k == 63), 6'(zz_order[k]), ref_mem[zz_order[k]]};
      er = {(k == 63), 6'(k), ref_mem[k]};
      exp_q.push_back({ez, er});
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 64; i++) ref_written[i] = 1'b0;
    ref_cnt      = 0;
    pending      = 0;
    ovf_exp      = 1'b0;
    beats_in_blk = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    dct_out_en = 1'b0;
    model_reset();
    tick();
    tick();
    chk("rst_in_ready",  64'(in_ready_z),  64'(1));
    chk("rst_out_valid", 64'(out_valid_z), 64'(0));
    chk("rst_out_data",  64'(out_data_z),  64'(0));
    chk("rst_out_idx",   64'(out_idx_z),   64'(0));
    chk("rst_out_last",  64'(out_last_z),  64'(0));
    chk("rst_ovf_err",   64'(ovf_z),       64'(0));
    chk("rst_out_valid_rs", 64'(out_valid_r), 64'(0));
    chk("rst_out_data_rs",  64'(out_data_r),  64'(0));
    reset = 1'b0;
    tick();
  endtask

  task automatic write_coef(input int idx, input logic [DW-1:0] data);
    bit exp_rdy;
    exp_rdy = (pending < 2);
    chk("in_ready_zz", 64'(in_ready_z), 64'(exp_rdy));
    chk("in_ready_rs", 64'(in_ready_r), 64'(exp_rdy));
    dct_out_en  = 1'b1;
    dct_out_idx = 6'(idx);
    dct_output  = data;
    if (exp_rdy) begin
      ref_mem[idx] = data;
      if (!ref_written[idx]) begin
        ref_written[idx] = 1'b1;
        ref_cnt++;
      end
      if (ref_cnt == 64) begin
        push_block();
        pending++;
        ref_cnt = 0;
        for (int i = 0; i < 64; i++) ref_written[i] = 1'b0;
      end
    end else begin
      ovf_exp = 1'b1;
    end
    tick();
    dct_out_en = 1'b0;
    chk("ovf_err_zz", 64'(ovf_z), 64'(ovf_exp));
    chk("ovf_err_rs", 64'(ovf_r), 64'(ovf_exp));
  endtask

  task automatic make_perm();
    int j, t;
    for (int i = 0; i < 64; i++) perm[i] = i;
    for (int i = 63; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
  endtask

  task automatic write_block(input int count);
    make_perm();
    for (int i = 0; i < count; i++) write_coef(perm[i], DW'($urandom_range(0, 8191)));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      tick();
      n++;
    end
    chk("drain_remaining", 64'(exp_q.size()), 64'(0));
    tick();
    tick();
    chk("idle_out_valid", 64'(out_valid_z), 64'(0));
    chk("idle_in_ready",  64'(in_ready_z),  64'(1));
  endtask

  // output monitor: sampled on the falling edge, away from the active edge
  always @(negedge clock) begin
    logic [2*EW-1:0] e;
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_zz", 64'({out_valid_z, out_last_z, out_idx_z, out_data_z}), 64'(hold_z));
        chk("hold_rs", 64'({out_valid_r, out_last_r, out_idx_r, out_data_r}), 64'(hold_r));
      end
      if (out_valid_z && out_ready) begin
        chk("beat_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("beat_zz", 64'({out_last_z, out_idx_z, out_data_z}), 64'(e[2*EW-1:EW]));
          chk("beat_rs_valid", 64'(out_valid_r), 64'(1));
          chk("beat_rs", 64'({out_last_r, out_idx_r, out_data_r}), 64'(e[EW-1:0]));
          if (e[EW-1]) begin
            pending--;
            beats_in_blk = 0;
          end else begin
            beats_in_blk++;
          end
        end
      end
      hold_v = out_valid_z && !out_ready;
      hold_z = {out_valid_z, out_last_z, out_idx_z, out_data_z};
      hold_r = {out_valid_r, out_last_r, out_idx_r, out_data_r};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    dct_out_en  = 1'b0;
    dct_out_idx = 6'd0;
    dct_output  = '0;
    out_ready   = 1'b1;
    rand_ready  = 1'b0;
    hold_v      = 1'b0;
    build_zz();
    do_reset();

    // index-ordered block with data = idx, plus latency of the first beat
    for (int i = 0; i < 64; i++) write_coef(i, DW'(i));
    chk("lat_T",  64'(out_valid_z), 64'(0));
    tick();
    chk("lat_T1", 64'(out_valid_z), 64'(0));
    tick();
    chk("lat_T2", 64'(out_valid_z), 64'(1));
    drain();

    // reverse order, index 5 rewritten with 99
    for (int i = 63; i >= 0; i--) begin
      write_coef(i, DW'(i));
      if (i == 5) write_coef(5, DW'(99));
    end
    drain();

    // three blocks with the output stalled: the third block overflows
    out_ready = 1'b0;
    write_block(64);
    write_block(64);
    write_block(64);
    chk("stall_ovf", 64'(ovf_z), 64'(1));
    out_ready = 1'b1;
    drain();

    // random backpressure over two blocks
    rand_ready = 1'b1;
    write_block(64);
    write_block(64);
    drain();
    rand_ready = 1'b0;
    out_ready  = 1'b1;

    // reset after a partial block, then reset mid-stream at beat 20
    write_block(30);
    do_reset();
    write_block(64);
    n = 0;
    while (beats_in_blk < 20 && n < 300) begin
      tick();
      n++;
    end
    chk("reached_beat20", 64'(beats_in_blk), 64'(20));
    do_reset();
    tick();
    tick();
    chk("post_rst_no_beat", 64'(out_valid_z), 64'(0));
    rand_ready = 1'b1;
    write_block(64);
    drain();
    rand_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
